tx_byte_timer: RTL and testbench
================================

Name: tx_byte_timer

Overview:
- Transmit-side counterpart of the receive bit/byte timer.
- Accepts a parallel byte on a valid/ready handshake and serializes it LSB first on a single line.
- Each bit is held for a programmable number of clocks.
- Emits per-bit and per-byte strobes so upstream packet logic can sequence bytes back-to-back with no idle gap.

Parameters:
- DATA_BITS, 8, bits per transmitted word; also sets the width of tx_data and bit_index.
- IDLE_LEVEL, 1, line level driven on tx_bit while idle and during reset.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_period  input  8  clocks per bit; sampled at byte load; a value of 0 is treated as 1.
- tx_data  input  DATA_BITS  byte to send; sampled at handshake.
- tx_start  input  1  request to send tx_data.
- tx_ready  output  1  block can accept a byte this cycle.
- tx_bit  output  1  serial line output, registered.
- bit_strobe  output  1  single-cycle pulse on the last clock of each bit.
- byte_done  output  1  single-cycle pulse on the last clock of the final bit.
- bit_index  output  $clog2(DATA_BITS)  index of the bit currently on tx_bit; 0 when idle.

Behaviour:
- Reset (synchronous, active-high, one clock):
  - state goes to IDLE; tx_bit=IDLE_LEVEL; tx_ready=1; bit_strobe=0; byte_done=0; bit_index=0.
  - All internal counters and the shift register clear.
- Reset mid-operation: the byte is abandoned; the line returns to IDLE_LEVEL on the next clock; there is no partial byte_done.
- States:
  - IDLE: tx_ready=1; tx_bit=IDLE_LEVEL.
  - SEND: byte in progress.
- Handshake: a byte is accepted only when tx_start and tx_ready are both 1 at a rising edge. tx_start with tx_ready=0 is ignored; nothing is queued.
- Load at edge N:
  - tx_data goes into the shift register; bit_period is latched (0 becomes 1).
  - The clock counter is set to 1 and bit_index to 0.
  - From cycle N+1: state=SEND, tx_bit=tx_data[0], tx_ready=0.
- Clock counter:
  - Counts 1..P, where P is the latched period.
  - bit_strobe=1 combinationally when count==P.
  - At that edge the counter wraps to 1, the shift register shifts right, and bit_index increments.
  - P=1 gives a new bit every clock.
- Final bit (bit_index==DATA_BITS-1 and count==P):
  - byte_done=1 and tx_ready=1 in that same cycle.
  - tx_start=1 in that cycle: the next byte loads; the next cycle drives new bit0 with no idle gap; state stays SEND.
  - Otherwise the next cycle goes to IDLE and tx_bit=IDLE_LEVEL.
- Each bit is held exactly P clocks, so a byte occupies exactly DATA_BITS*P clocks.
- Changing bit_period during SEND has no effect until the next load.
- tx_bit is always a registered output (glitch-free).
- Outputs are never X after the first reset edge.

Test Plan:
- Reset: hold rst 2 clocks, then release -> tx_bit=1, tx_ready=1, strobes 0, bit_index 0.
- Single byte, tx_data=8'hA5, bit_period=4, pulse tx_start one cycle:
  - tx_bit sequence is 1,0,1,0,0,1,0,1, each bit held 4 clocks (32 clocks total).
  - 8 bit_strobe pulses spaced 4 apart.
  - byte_done coincides with the 8th strobe.
  - Line returns to 1 the next cycle.
- Back-to-back: tx_data=8'h01, then 8'hFF presented with tx_start held high, bit_period=2:
  - Second byte loads in the byte_done cycle.
  - 32 contiguous clocks of data with no idle cycle; tx_ready high only on the byte_done cycles.
- bit_period=0 and bit_period=1, tx_data=8'h3C:
  - Both give one bit per clock; byte_done 8 clocks after the load edge.
  - No stall or hang in either case.
- Ignored request: assert tx_start with 8'h00 at bit 3 of an in-flight 8'hF0 -> 8'hF0 completes intact; 8'h00 is never sent.
- Mid-byte reset: assert rst at bit 5 of 8'h55, bit_period=3:
  - Next cycle tx_bit=1, tx_ready=1, no byte_done.
  - A fresh tx_start then sends a complete byte correctly.

Source files
------------

// File: rtl/tx_byte_timer.sv
// Serial byte transmitter: shifts a parallel word out LSB first, holding each bit
// for a programmable number of clocks, with per-bit and per-byte strobes.
module tx_byte_timer #(
  parameter int   DATA_BITS  = 8,
  parameter logic IDLE_LEVEL = 1'b1,
  localparam int  IW         = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           bit_period,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_ready,
  output logic                 tx_bit,
  output logic                 bit_strobe,
  output logic                 byte_done,
  output logic [IW-1:0]        bit_index
);
  localparam logic [0:0]    S_IDLE   = 1'b0;
  localparam logic [0:0]    S_SEND   = 1'b1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  logic [0:0]           state;
  logic [7:0]           period;
  logic [7:0]           count;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shifted;
  logic [IW-1:0]        idx_q;
  logic                 at_end;
  logic                 load;

  assign at_end     = (state == S_SEND) && (count == period);
  assign bit_strobe = at_end;
  assign byte_done  = at_end && (idx_q == LAST_IDX);
  // Ready during the final clock lets the next byte load with no idle gap.
  assign tx_ready   = (state == S_IDLE) || byte_done;
  assign load       = tx_start && tx_ready;
  assign shifted    = shreg >> 1;
  assign bit_index  = idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      period <= '0;
      count  <= '0;
      shreg  <= '0;
      idx_q  <= '0;
      tx_bit <= IDLE_LEVEL;
    end else if (load) begin
      state  <= S_SEND;
      shreg  <= tx_data;
      period <= (bit_period == 8'd0) ? 8'd1 : bit_period;
      count  <= 8'd1;
      idx_q  <= '0;
      tx_bit <= tx_data[0];
    end else if (byte_done) begin
      state  <= S_IDLE;
      count  <= '0;
      shreg  <= '0;
      idx_q  <= '0;
      tx_bit <= IDLE_LEVEL;
    end else if (bit_strobe) begin
      count  <= 8'd1;
      shreg  <= shifted;
      idx_q  <= idx_q + 1'b1;
      tx_bit <= shifted[0];
    end else if (state == S_SEND) begin
      count  <= count + 8'd1;
    end
  end
endmodule

// File: tb/tb_tx_byte_timer.sv
// Scoreboard bench for tx_byte_timer: stimulus pushes the expected bit/strobe
// schedule, a negedge monitor pops and compares on every bit_strobe.
module tb_tx_byte_timer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] bit_period = 8'd1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_ready, tx_bit, bit_strobe, byte_done;
  logic [2:0] bit_index;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    logic b;
    int   idx;
    logic done;
    int   cyc;
  } exp_t;
  exp_t sb[$];

  tx_byte_timer #(.DATA_BITS(8), .IDLE_LEVEL(1'b1)) dut (
    .clk(clk), .rst(rst), .bit_period(bit_period), .tx_data(tx_data),
    .tx_start(tx_start), .tx_ready(tx_ready), .tx_bit(tx_bit),
    .bit_strobe(bit_strobe), .byte_done(byte_done), .bit_index(bit_index)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected schedule: bit i is on the line from t0+i*p and strobes at t0+(i+1)*p-1.
  task automatic push_byte(input logic [7:0] d, input int p, input int t0, input int nb);
    exp_t e;
    for (int i = 0; i < nb; i++) begin
      e.b    = d[i];
      e.idx  = i;
      e.done = (i == 7);
      e.cyc  = t0 + (i + 1) * p - 1;
      sb.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int target);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (cyc < target && g < 2000);
    if (cyc != target) check("wait_timeout", cyc, target);
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] p, input int nb, output int t0);
    @(negedge clk);
    tx_data = d; bit_period = p; tx_start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    tx_start = 1'b0;
    push_byte(d, (p == 8'd0) ? 1 : int'(p), t0, nb);
  endtask

  task automatic check_idle(input string name);
    check({name, "_tx_bit"}, tx_bit, 1);
    check({name, "_ready"}, tx_ready, 1);
    check({name, "_strobe"}, bit_strobe, 0);
    check({name, "_done"}, byte_done, 0);
    check({name, "_index"}, bit_index, 0);
  endtask

  // Monitor: every strobe must match the next scheduled bit; byte_done never alone.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bit_strobe) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          e = sb.pop_front();
          check("strobe_cycle", cyc, e.cyc);
          check("strobe_tx_bit", tx_bit, e.b);
          check("strobe_index", bit_index, e.idx);
          check("strobe_done", byte_done, e.done);
          check("strobe_ready", tx_ready, e.done);
        end
      end else if (byte_done) begin
        check("done_without_strobe", 1, 0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, t1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle("in_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("after_reset");

    // Single byte A5 at P=4; bit_period changes mid-byte must not matter.
    send(8'hA5, 8'd4, 8, t0);
    bit_period = 8'd9;
    wait_cyc(t0 + 2);
    check("a5_ready_busy", tx_ready, 0);
    check("a5_bit0", tx_bit, 1);
    wait_cyc(t0 + 32);
    check_idle("a5_end");

    // Back-to-back 01 then FF at P=2 with tx_start held.
    @(negedge clk);
    tx_data = 8'h01; bit_period = 8'd2; tx_start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    t1 = t0 + 16;
    push_byte(8'h01, 2, t0, 8);
    push_byte(8'hFF, 2, t1, 8);
    tx_data = 8'hFF;
    wait_cyc(t0 + 5);
    check("b2b_ready_mid", tx_ready, 0);
    check("b2b_bit_mid", tx_bit, 0);
    wait_cyc(t1);
    tx_start = 1'b0;
    check("b2b_second_bit0", tx_bit, 1);
    check("b2b_ready_second", tx_ready, 0);
    wait_cyc(t1 + 32 - 16);
    check_idle("b2b_end");

    // Period 0 and 1 both give one bit per clock.
    send(8'h3C, 8'd0, 8, t0);
    wait_cyc(t0 + 8);
    check_idle("p0_end");
    send(8'h3C, 8'd1, 8, t0);
    wait_cyc(t0 + 8);
    check_idle("p1_end");

    // Request during bit 3 of F0 is dropped.
    send(8'hF0, 8'd2, 8, t0);
    wait_cyc(t0 + 6);
    tx_data = 8'h00; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_cyc(t0 + 16);
    check_idle("ignored_end");
    repeat (20) @(negedge clk);
    check("ignored_queue", sb.size(), 0);

    // Reset during bit 5 of 55 at P=3: only bits 0..4 strobe.
    send(8'h55, 8'd3, 5, t0);
    wait_cyc(t0 + 15);
    rst = 1'b1;
    @(negedge clk);
    check_idle("midreset");
    rst = 1'b0;
    @(negedge clk);
    check_idle("midreset_after");
    send(8'h96, 8'd2, 8, t0);
    wait_cyc(t0 + 16);
    check_idle("fresh_end");

    repeat (10) @(negedge clk);
    check("final_queue_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
